marker_coord_arbiter: RTL and testbench
=======================================

# marker_coord_arbiter

- Arbitrates between two coordinate requesters (0 = host/UART command path, 1 = on-chip tracker) and owns the marker-box coordinates consumed by the grayscale display datapath (driven_coordinates_x/y).
- Accepted updates are clamped and staged; they are committed only at a frame boundary, so the box never tears mid-frame.
- Optionally blanks the marker when no fresh coordinate has arrived for a configurable number of frames.

## Interface
Parameters:
- MAX_X, 639, largest legal x coordinate; larger requests clamp to it
- MAX_Y, 479, largest legal y coordinate; larger requests clamp to it
- TIMEOUT_FRAMES, 30, stale-frame limit before the marker is blanked (used only with MARKER_TIMEOUT_EN)

Ports (reset iRST, asynchronous, active-low; clock iCLK):
- iCLK  in  1  pixel clock, same as the display datapath
- iRST  in  1  asynchronous active-low reset
- iY_Cont  in  11  current sensor row counter
- iReq  in  2  per-requester update request, level
- iX0 / iY0  in  10 / 9  requester 0 coordinates
- iX1 / iY1  in  10 / 9  requester 1 coordinates
- oAck  out  2  one-cycle grant acknowledge, one-hot
- oCoord_x  out  10  committed x, drives driven_coordinates_x
- oCoord_y  out  9  committed y, drives driven_coordinates_y
- oMarker_en  out  1  marker box display enable
- oFrame_tick  out  1  one-cycle frame-boundary pulse, for debug and tracker sync

## Operation
- FSM states are S_IDLE and S_ACK. Reset state is S_IDLE.
- In S_IDLE, if any iReq bit is high, pick a winner:
  - Round-robin pointer rr selects who has priority. Reset value is 0, so requester 0 has priority.
  - If only one requester is asking, it wins regardless of rr.
- On the grant edge:
  - Store the winner's clamped coordinates into staged_x/staged_y and set staged_valid=1.
  - Set rr to the other requester.
  - Go to S_ACK.
- In S_ACK:
  - oAck[winner]=1 for exactly this one cycle.
  - Return to S_IDLE unconditionally.
  - iReq is ignored in this state.
  - A requester must drop iReq on the cycle after it sees oAck. If it keeps iReq high, that is treated as a new request.
- Clamp rule: x_out = (x > MAX_X) ? MAX_X : x, and likewise for y. Compare unsigned at full input width.
- Multiple grants within one frame overwrite the staged value (last writer wins). Each grant is still acked.
- Frame tick:
  - y_prev is a register of iY_Cont.
  - tick = (iY_Cont == 0) && (y_prev != 0), registered to form oFrame_tick.
  - y_prev resets to 0, so there is no tick out of reset until the row counter has left row 0.
- Commit:
  - On the oFrame_tick cycle, if staged_valid=1, then oCoord <= staged, staged_valid <= 0, and oMarker_en <= 1.
  - If staged_valid=0, the outputs hold.
- Simultaneous grant and commit on the same edge:
  - The commit takes the pre-edge staged value.
  - The new grant writes staged and leaves staged_valid=1, so it commits at the next frame.
- Reset mid-operation: all state clears immediately. Any pending ack is dropped and not replayed.

## Timing
- Reset values: oCoord_x=0, oCoord_y=0, oMarker_en=0, oAck=0, oFrame_tick=0, staged_valid=0, rr=0, state=S_IDLE.
- Request sampled at edge N: staged updated at edge N+1; oAck high during cycle N+1 to N+2.
- Maximum grant throughput: one grant per 2 cycles.
- Tick latency: iY_Cont wraps to 0 at edge T, so oFrame_tick is high during cycle T+1 to T+2.
- Commit latency: oCoord changes at edge T+2.
- Worst-case request-to-display latency: one frame plus 3 cycles.

## Configuration
- Macro: MARKER_TIMEOUT_EN.
- When defined:
  - An 8-bit stale counter clears on every commit.
  - It increments, saturating, on each oFrame_tick that has no commit.
  - When it reaches TIMEOUT_FRAMES, oMarker_en <= 0 on that tick edge.
  - oCoord holds its last value.
  - The next commit re-asserts oMarker_en.
- When undefined:
  - No counter is built.
  - oMarker_en rises on the first commit and stays 1 until reset.

## Structure
- Package marker_pkg holds:
  - COORD_X_W=10 and COORD_Y_W=9.
  - The state enum typedef marker_state_t {S_IDLE, S_ACK}.
  - The REQ_HOST=0 and REQ_TRK=1 constants.
- One sub-module, frame_tick_detect (iCLK, iRST, iY_Cont, oTick), contains y_prev and the registered tick.
- Arbitration, clamp, staging, commit and timeout logic all live in the top module.

## Test plan
- **Reset:**
  - Stimulus: assert iRST low mid-S_ACK.
  - Required response: oAck=0, oCoord=(0,0), oMarker_en=0 next cycle; no ack after release.
- **Single request with clamp:**
  - Stimulus: iReq=01, iX0=700, iY0=500.
  - Required response: oAck=01 one cycle; after the next iY_Cont wrap, oCoord=(639,479), oMarker_en=1.
- **Round-robin:**
  - Stimulus: iReq=11 held, each requester dropping its bit after its ack.
  - Required response: acks 01 then 10; from a fresh reset with both high, the order alternates starting at requester 0.
- **Last writer wins:**
  - Stimulus: requester 0 (100,50) then requester 1 (200,60), both within one frame.
  - Required response: commit shows (200,60) only.
- **Grant on the tick edge:**
  - Stimulus: grant of (300,40) lands on the oFrame_tick edge while staged holds (10,10).
  - Required response: commit (10,10); (300,40) commits at the following frame.
- **Timeout (MARKER_TIMEOUT_EN, TIMEOUT_FRAMES=3):**
  - Stimulus: one commit, then 3 frames with no requests.
  - Required response: oMarker_en falls on the 3rd tick; a new request re-enables it at the next frame.

Source files
------------

// File: rtl/marker_pkg.sv
// rtl/marker_pkg.sv - shared widths, requester ids and FSM state type for the marker coordinate arbiter
package marker_pkg;

  localparam int COORD_X_W = 10;
  localparam int COORD_Y_W = 9;

  localparam int REQ_HOST = 0;
  localparam int REQ_TRK  = 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } marker_state_t;

endpackage

// File: rtl/marker_coord_arbiter_frame_tick_detect.sv
// rtl/marker_coord_arbiter_frame_tick_detect.sv - registered one-cycle pulse when the sensor row counter wraps to row 0
module frame_tick_detect (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [10:0] iY_Cont,
  output logic        oTick
);

  logic [10:0] y_prev_q, y_prev_d;
  logic        tick_q, tick_d;

  // y_prev clears to 0 on reset, so sitting on row 0 out of reset is not a wrap
  always_comb begin
    y_prev_d = iY_Cont;
    tick_d   = (iY_Cont == 11'd0) && (y_prev_q != 11'd0);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      y_prev_q <= 11'd0;
      tick_q   <= 1'b0;
    end else begin
      y_prev_q <= y_prev_d;
      tick_q   <= tick_d;
    end
  end

  assign oTick = tick_q;

endmodule

// File: rtl/marker_coord_arbiter.sv
// rtl/marker_coord_arbiter.sv - two-requester round-robin arbiter that clamps, stages and frame-commits marker coordinates
// Optional stale-marker blanking is built when MARKER_TIMEOUT_EN is defined.
module marker_coord_arbiter
  import marker_pkg::*;
#(
  parameter int MAX_X          = 639,
  parameter int MAX_Y          = 479,
  parameter int TIMEOUT_FRAMES = 30
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [10:0]          iY_Cont,
  input  logic [1:0]           iReq,
  input  logic [COORD_X_W-1:0] iX0,
  input  logic [COORD_Y_W-1:0] iY0,
  input  logic [COORD_X_W-1:0] iX1,
  input  logic [COORD_Y_W-1:0] iY1,
  output logic [1:0]           oAck,
  output logic [COORD_X_W-1:0] oCoord_x,
  output logic [COORD_Y_W-1:0] oCoord_y,
  output logic                 oMarker_en,
  output logic                 oFrame_tick
);

  localparam logic [COORD_X_W-1:0] MAX_X_C = COORD_X_W'(MAX_X);
  localparam logic [COORD_Y_W-1:0] MAX_Y_C = COORD_Y_W'(MAX_Y);

  marker_state_t        state_q, state_d;
  logic                 rr_q, rr_d;
  logic [1:0]           ack_q, ack_d;
  logic [COORD_X_W-1:0] staged_x_q, staged_x_d, coord_x_q, coord_x_d;
  logic [COORD_Y_W-1:0] staged_y_q, staged_y_d, coord_y_q, coord_y_d;
  logic                 staged_valid_q, staged_valid_d;
  logic                 marker_en_q, marker_en_d;

  logic                 frame_tick;
  logic                 commit;
  logic                 win;
  logic [COORD_X_W-1:0] sel_x;
  logic [COORD_Y_W-1:0] sel_y;

`ifdef MARKER_TIMEOUT_EN
  logic [7:0]           stale_q, stale_d;
`endif

  frame_tick_detect u_frame_tick (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iY_Cont (iY_Cont),
    .oTick   (frame_tick)
  );

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    ack_d          = 2'b00;
    staged_x_d     = staged_x_q;
    staged_y_d     = staged_y_q;
    staged_valid_d = staged_valid_q;
    coord_x_d      = coord_x_q;
    coord_y_d      = coord_y_q;
    marker_en_d    = marker_en_q;
    win            = rr_q;
    sel_x          = iX0;
    sel_y          = iY0;
`ifdef MARKER_TIMEOUT_EN
    stale_d        = stale_q;
`endif

    // Commit consumes the pre-edge staged value; a grant below may re-arm staged_valid
    commit = frame_tick && staged_valid_q;
    if (commit) begin
      coord_x_d      = staged_x_q;
      coord_y_d      = staged_y_q;
      marker_en_d    = 1'b1;
      staged_valid_d = 1'b0;
    end

`ifdef MARKER_TIMEOUT_EN
    if (commit) begin
      stale_d = 8'd0;
    end else if (frame_tick) begin
      if (stale_q != 8'hFF) begin
        stale_d = stale_q + 8'd1;
      end
      if (32'(stale_d) >= 32'(TIMEOUT_FRAMES)) begin
        marker_en_d = 1'b0;
      end
    end
`endif

    if (state_q == S_IDLE) begin
      if (iReq != 2'b00) begin
        win   = (iReq == 2'b11) ? rr_q : iReq[REQ_TRK];
        sel_x = win ? iX1 : iX0;
        sel_y = win ? iY1 : iY0;
        staged_x_d     = (32'(sel_x) > 32'(MAX_X)) ? MAX_X_C : sel_x;
        staged_y_d     = (32'(sel_y) > 32'(MAX_Y)) ? MAX_Y_C : sel_y;
        staged_valid_d = 1'b1;
        rr_d           = ~win;
        ack_d          = win ? (2'b01 << REQ_TRK) : (2'b01 << REQ_HOST);
        state_d        = S_ACK;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q        <= S_IDLE;
      rr_q           <= 1'b0;
      ack_q          <= 2'b00;
      staged_x_q     <= '0;
      staged_y_q     <= '0;
      staged_valid_q <= 1'b0;
      coord_x_q      <= '0;
      coord_y_q      <= '0;
      marker_en_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      ack_q          <= ack_d;
      staged_x_q     <= staged_x_d;
      staged_y_q     <= staged_y_d;
      staged_valid_q <= staged_valid_d;
      coord_x_q      <= coord_x_d;
      coord_y_q      <= coord_y_d;
      marker_en_q    <= marker_en_d;
    end
  end

`ifdef MARKER_TIMEOUT_EN
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      stale_q <= 8'd0;
    end else begin
      stale_q <= stale_d;
    end
  end
`endif

  assign oAck        = ack_q;
  assign oCoord_x    = coord_x_q;
  assign oCoord_y    = coord_y_q;
  assign oMarker_en  = marker_en_q;
  assign oFrame_tick = frame_tick;

endmodule

// File: tb/tb_marker_coord_arbiter.sv
// tb/tb_marker_coord_arbiter.sv - directed and randomized bench for marker_coord_arbiter against a transaction-level model
module tb_marker_coord_arbiter;

  localparam int MX          = 639;
  localparam int MY          = 479;
  localparam int TF          = 3;
  localparam int FRAME_ROWS  = 24;
  localparam int RAND_CYCLES = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] yc = 11'd0;
  logic [1:0]  req = 2'b00;
  logic [9:0]  x0 = '0, x1 = '0;
  logic [8:0]  y0 = '0, y1 = '0;
  logic [1:0]  ack;
  logic [9:0]  cx;
  logic [8:0]  cy;
  logic        en;
  logic        tick;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_on  = 1'b0;

  always #5 clk = ~clk;

  marker_coord_arbiter #(
    .MAX_X          (MX),
    .MAX_Y          (MY),
    .TIMEOUT_FRAMES (TF)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst_n),
    .iY_Cont     (yc),
    .iReq        (req),
    .iX0         (x0),
    .iY0         (y0),
    .iX1         (x1),
    .iY1         (y1),
    .oAck        (ack),
    .oCoord_x    (cx),
    .oCoord_y    (cy),
    .oMarker_en  (en),
    .oFrame_tick (tick)
  );

  typedef struct packed {
    int ack;
    int rr;
    int stx;
    int sty;
    bit sv;
    int cx;
    int cy;
    bit en;
    bit tick;
    int yprev;
    int stale;
  } mstate_t;

  mstate_t m;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One clock of the arbiter described as transactions: frame wrap, commit, then grant or ack retire
  function automatic mstate_t model_step(input mstate_t s, input logic [1:0] r,
                                         input int ax0, input int ay0, input int ax1, input int ay1,
                                         input int y);
    mstate_t n;
    int w;
    n = s;
    n.tick  = (y == 0) && (s.yprev != 0);
    n.yprev = y;
    if (s.tick && s.sv) begin
      n.cx = s.stx;
      n.cy = s.sty;
      n.en = 1'b1;
      n.sv = 1'b0;
      n.stale = 0;
    end
`ifdef MARKER_TIMEOUT_EN
    else if (s.tick) begin
      if (s.stale < 255) n.stale = s.stale + 1;
      if (n.stale >= TF) n.en = 1'b0;
    end
`endif
    if (s.ack != 0) begin
      n.ack = 0;
    end else if (r != 2'b00) begin
      w = (r == 2'b11) ? s.rr : ((r == 2'b10) ? 1 : 0);
      n.stx = (w == 1) ? ((ax1 > MX) ? MX : ax1) : ((ax0 > MX) ? MX : ax0);
      n.sty = (w == 1) ? ((ay1 > MY) ? MY : ay1) : ((ay0 > MY) ? MY : ay0);
      n.sv  = 1'b1;
      n.rr  = 1 - w;
      n.ack = 1 << w;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= model_step(m, req, int'(x0), int'(y0), int'(x1), int'(y1), int'(yc));
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("oAck", int'(ack), m.ack);
      chk("oCoord_x", int'(cx), m.cx);
      chk("oCoord_y", int'(cy), m.cy);
      chk("oMarker_en", int'(en), int'(m.en));
      chk("oFrame_tick", int'(tick), int'(m.tick));
    end
  end

  task automatic do_req(input int r, input int x, input int y);
    bit got;
    if (r == 0) begin x0 = 10'(x); y0 = 9'(y); end
    else begin x1 = 10'(x); y1 = 9'(y); end
    req[r] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack[r]) got = 1'b1;
    end
    chk("ack_wait", int'(got), 1);
    req[r] = 1'b0;
  endtask

  task automatic wait_any(output int a);
    a = 0;
    for (int i = 0; i < 8 && a == 0; i++) begin
      @(negedge clk);
      a = int'(ack);
    end
    chk("ack_any_wait", int'(a != 0), 1);
  endtask

  task automatic wrap();
    yc = 11'd7;
    @(negedge clk);
    yc = 11'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a1, a2;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", int'(ack), 0);
    chk("rst_x", int'(cx), 0);
    chk("rst_y", int'(cy), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_tick", int'(tick), 0);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    do_req(0, 700, 500);
    wrap();
    chk("clamp_x", int'(cx), 639);
    chk("clamp_y", int'(cy), 479);
    chk("clamp_en", int'(en), 1);

    do_req(0, 100, 50);
    do_req(1, 200, 60);
    wrap();
    chk("lastwr_x", int'(cx), 200);
    chk("lastwr_y", int'(cy), 60);

    do_req(0, 10, 10);
    yc = 11'd7;
    @(negedge clk);
    yc = 11'd0;
    @(negedge clk);
    chk("edge_tick", int'(tick), 1);
    x0 = 10'd300; y0 = 9'd40; req = 2'b01;
    @(negedge clk);
    chk("edge_commit_x", int'(cx), 10);
    chk("edge_commit_y", int'(cy), 10);
    chk("edge_ack", int'(ack), 1);
    req = 2'b00;
    wrap();
    chk("edge_next_x", int'(cx), 300);
    chk("edge_next_y", int'(cy), 40);

    x0 = 10'd5; y0 = 9'd5; req = 2'b01;
    @(negedge clk);
    chk("pre_rst_ack", int'(ack), 1);
    #2 rst_n = 1'b0;
    req = 2'b00;
    #1;
    chk("midrst_ack", int'(ack), 0);
    chk("midrst_x", int'(cx), 0);
    chk("midrst_y", int'(cy), 0);
    chk("midrst_en", int'(en), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_replay_ack", int'(ack), 0);
    end

    x0 = 10'd11; y0 = 9'd12; x1 = 10'd21; y1 = 9'd22;
    req = 2'b11;
    wait_any(a1);
    req = req & ~2'(a1);
    wait_any(a2);
    req = req & ~2'(a2);
    chk("rr_first", a1, 1);
    chk("rr_second", a2, 2);
    wrap();
    chk("rr_commit_x", int'(cx), 21);
    chk("rr_commit_y", int'(cy), 22);

    do_req(0, 5, 6);
    wrap();
    chk("to_commit_en", int'(en), 1);
    wrap();
    wrap();
    chk("to_two_ticks_en", int'(en), 1);
    wrap();
`ifdef MARKER_TIMEOUT_EN
    chk("to_third_tick_en", int'(en), 0);
    chk("to_hold_x", int'(cx), 5);
    do_req(1, 7, 8);
    wrap();
    chk("to_reenable_en", int'(en), 1);
    chk("to_reenable_x", int'(cx), 7);
`else
    chk("no_timeout_en", int'(en), 1);
    chk("no_timeout_x", int'(cx), 5);
`endif

    for (int c = 0; c < RAND_CYCLES; c++) begin
      yc = (int'(yc) >= FRAME_ROWS - 1) ? 11'd0 : yc + 11'd1;
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      for (int r = 0; r < 2; r++) begin
        if (ack[r]) begin
          req[r] = ($urandom_range(0, 7) == 0);
        end else if (!req[r] && $urandom_range(0, 3) == 0) begin
          req[r] = 1'b1;
          if (r == 0) begin
            x0 = 10'($urandom_range(0, 1023));
            y0 = 9'($urandom_range(0, 511));
          end else begin
            x1 = 10'($urandom_range(0, 1023));
            y1 = 9'($urandom_range(0, 511));
          end
        end
      end
      @(negedge clk);
    end

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
